// File: rtl/wind_txburst.sv
// Transmit-side burst sequencer for the ultrasonic anemometer: carrier burst, guard gap, RX sample window.
// Optional dead-time insertion on the H-bridge drive is enabled by defining WIND_DEADTIME_EN.
module wind_txburst #(
  parameter int HALFPER = 624,
  parameter int SAMPDIV = 312,
  parameter int DT      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  npulses,
  input  logic [15:0] guard,
  input  logic [11:0] rxlen,
  output logic        txp,
  output logic        txn,
  output logic        busy,
  output logic        rxwin,
  output logic        endata,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, TX, GUARD, RX, DONE} state_t;

`ifdef WIND_DEADTIME_EN
  localparam int DT_USE = 1;
`else
  localparam int DT_USE = 0;
`endif

  localparam int SMAX = (HALFPER > SAMPDIV) ? HALFPER : SAMPDIV;
  localparam int SW   = $clog2(SMAX + 1);
  localparam logic [SW-1:0] HP_LAST = SW'(HALFPER - 1);
  localparam logic [SW-1:0] SD_LAST = SW'(SAMPDIV - 1);
  // Drive is active while the in-half counter is below this limit; the rest of the half is dead time.
  localparam logic [SW-1:0] ON_LIM  = SW'(HALFPER - DT * DT_USE);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [SW-1:0] sub_reg, sub_next;
  logic        half_reg, half_next;
  logic [4:0]  npulses_reg, npulses_next;
  logic [15:0] guard_reg, guard_next;
  logic [11:0] rxlen_reg, rxlen_next;
  logic        txp_reg, txn_reg, busy_reg, rxwin_reg, endata_reg, done_reg;

  logic [15:0] tx_last;
  state_t      post_tx, post_guard;

  always_comb begin
    tx_last    = {11'd0, (npulses_reg == 5'd0) ? 5'd0 : (npulses_reg - 5'd1)};
    post_guard = (rxlen_reg != 12'd0) ? RX : DONE;
    post_tx    = (guard_reg != 16'd0) ? GUARD : post_guard;
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    sub_next     = sub_reg;
    half_next    = half_reg;
    npulses_next = npulses_reg;
    guard_next   = guard_reg;
    rxlen_next   = rxlen_reg;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          npulses_next = npulses;
          guard_next   = guard;
          rxlen_next   = rxlen;
          state_next   = TX;
          cnt_next     = '0;
          sub_next     = '0;
          half_next    = 1'b0;
        end
      end
      TX: begin
        if (sub_reg == HP_LAST) begin
          sub_next  = '0;
          half_next = ~half_reg;
          if (half_reg) begin
            if (cnt_reg == tx_last) begin
              state_next = post_tx;
              cnt_next   = '0;
              half_next  = 1'b0;
            end else begin
              cnt_next = cnt_reg + 16'd1;
            end
          end
        end else begin
          sub_next = sub_reg + SW'(1);
        end
      end
      GUARD: begin
        if (cnt_reg == guard_reg - 16'd1) begin
          state_next = post_guard;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      RX: begin
        if (sub_reg == SD_LAST) begin
          sub_next = '0;
          if (cnt_reg == {4'd0, rxlen_reg} - 16'd1) begin
            state_next = DONE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 16'd1;
          end
        end else begin
          sub_next = sub_reg + SW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
        sub_next   = '0;
        half_next  = 1'b0;
      end
      default: state_next = IDLE;
    endcase

    // Abort leaves the shadow registers alone so they can be inspected after the fact.
    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
      cnt_next   = '0;
      sub_next   = '0;
      half_next  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      sub_reg     <= '0;
      half_reg    <= 1'b0;
      npulses_reg <= '0;
      guard_reg   <= '0;
      rxlen_reg   <= '0;
      txp_reg     <= 1'b0;
      txn_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      rxwin_reg   <= 1'b0;
      endata_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      sub_reg     <= sub_next;
      half_reg    <= half_next;
      npulses_reg <= npulses_next;
      guard_reg   <= guard_next;
      rxlen_reg   <= rxlen_next;
      // Outputs are decoded from the next state so they line up with the state they describe.
      txp_reg     <= (state_next == TX) && !half_next && (sub_next < ON_LIM);
      txn_reg     <= (state_next == TX) &&  half_next && (sub_next < ON_LIM);
      busy_reg    <= (state_next != IDLE);
      rxwin_reg   <= (state_next == RX);
      endata_reg  <= (state_next == RX) && (sub_next == '0);
      done_reg    <= (state_next == DONE);
    end
  end

  assign txp    = txp_reg;
  assign txn    = txn_reg;
  assign busy   = busy_reg;
  assign rxwin  = rxwin_reg;
  assign endata = endata_reg;
  assign done   = done_reg;

endmodule
